// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone classic master that copies a block of 32-bit words,
// one read phase then one write phase per word, all inside a single held cyc.
module wb_dma_copy #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  count_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i
);
    // Watchdog wide enough to hold TIMEOUT_CYCLES-1; expiry is on the cycle
    // that would be the TIMEOUT_CYCLES-th one spent waiting in a phase.
    localparam int WDT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST =
        WDT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [31:0]           buf_q, buf_d;
    logic [WDT_W-1:0]      wdt_q, wdt_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  wdt_exp, bus_fault;

    assign wdt_exp   = (TIMEOUT_CYCLES != 0) && (wdt_q == WDT_LAST);
    // An error response beats a simultaneous ack.
    assign bus_fault = wbm_err_i | wdt_exp;

    // State register and all datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            wdt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            wdt_q   <= wdt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: start handling, phase hand-off on ack, error abort.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        wdt_d   = '0;   // cleared on every phase change and while idle
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = src_i & WORD_MASK;
                        dst_d   = dst_i & WORD_MASK;
                        len_d   = len_i;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus_fault) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (wbm_ack_i) begin
                    buf_d   = wbm_dat_i;
                    state_d = S_WRITE;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            S_WRITE: begin
                if (bus_fault) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (wbm_ack_i) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    src_d = src_q + ADDR_WIDTH'(4);
                    dst_d = dst_q + ADDR_WIDTH'(4);
                    if (cnt_q + LEN_WIDTH'(1) == len_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and status outputs decode straight from registered state.
    always_comb begin
        busy_o    = (state_q != S_IDLE);
        wbm_cyc_o = busy_o;
        wbm_stb_o = busy_o;
        wbm_we_o  = (state_q == S_WRITE);
        wbm_sel_o = busy_o ? 4'hF : 4'h0;
        wbm_adr_o = (state_q == S_READ)  ? src_q :
                    (state_q == S_WRITE) ? dst_q : '0;
        wbm_dat_o = (state_q == S_WRITE) ? buf_q : '0;
        done_o    = done_q;
        err_o     = err_q;
        count_o   = cnt_q;
    end
endmodule

// File: doc/wb_dma_copy.md
# wb_dma_copy

Wishbone classic master engine that copies a block of 32-bit words from a source byte address to a destination byte address. It sits beside the CPU as a second bus initiator and drives the same Wishbone slaves the CPU uses (SRAM, peripherals). Software-side control is a simple start/length/status interface, exposed directly or through a CSR wrapper. Each word is copied as one read cycle followed by one write cycle within a single held `cyc`.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: Wishbone byte-address width.
- `LEN_WIDTH`, default 16: width of the word count.
- `TIMEOUT_CYCLES`, default 255: maximum wait for `ack`/`err` per phase. A value of 0 disables the watchdog.

Ports:
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: reset, synchronous and active-high.
- `start_i`  in  1: start request. Sampled only while idle.
- `src_i`  in  ADDR_WIDTH: source byte address. Bits [1:0] are ignored and treated as 0.
- `dst_i`  in  ADDR_WIDTH: destination byte address. Bits [1:0] are ignored and treated as 0.
- `len_i`  in  LEN_WIDTH: number of words to copy.
- `busy_o`  out  1: high while a transfer is in progress.
- `done_o`  out  1: one-cycle pulse at the end of a transfer, on both success and error.
- `err_o`  out  1: sticky error flag. Cleared only by an accepted start.
- `count_o`  out  LEN_WIDTH: number of words completed in the current or last transfer.
- `wbm_cyc_o`  out  1: Wishbone cycle.
- `wbm_stb_o`  out  1: Wishbone strobe.
- `wbm_adr_o`  out  ADDR_WIDTH: Wishbone address. Always word-aligned.
- `wbm_we_o`  out  1: Wishbone write enable.
- `wbm_sel_o`  out  4: byte selects. Always 4'hF during a cycle, 0 otherwise.
- `wbm_dat_o`  out  32: write data.
- `wbm_dat_i`  in  32: read data.
- `wbm_ack_i`  in  1: Wishbone acknowledge.
- `wbm_err_i`  in  1: Wishbone error.

## Operation

States: IDLE, READ, WRITE.

- **IDLE**
  - `start_i`=1 with `len_i`≠0: latch `src`, `dst` and `len`; clear `count_o` and `err_o`; go to READ.
  - `start_i`=1 with `len_i`=0: clear `err_o` and `count_o`; pulse `done_o` in the next cycle; no bus activity; `busy_o` stays 0.
- **READ**
  - Outputs: `cyc`=`stb`=1, `we`=0, `adr`=current source address.
  - On `ack`: latch `wbm_dat_i` into the word buffer; go to WRITE.
- **WRITE**
  - Outputs: `cyc`=`stb`=1, `we`=1, `adr`=current destination address, `dat_o`=buffer.
  - On `ack`: increment `count_o`; add 4 to both addresses, modulo 2^ADDR_WIDTH (wrap-around is silent).
  - If `count_o`+1 == `len`: go to IDLE, drop `cyc`/`stb`/`we`/`sel`, pulse `done_o`.
  - Otherwise: go to READ.
- **Holding `cyc`:** `cyc` stays high for the whole transfer. `stb` stays high continuously; each `ack` ends one phase.
- **Error:** `wbm_err_i`=1 in READ or WRITE, or a watchdog expiry, has this effect in the next cycle:
  - `cyc`/`stb` go low;
  - `err_o`=1 and `done_o` pulses;
  - the state returns to IDLE;
  - `count_o` holds the number of completed words.
- **`ack` and `err` together:** the error wins.
- **Watchdog:** counts cycles spent in the current phase without `ack`/`err`. It resets on every phase change. Reaching `TIMEOUT_CYCLES` is an error.
- **`start_i` while busy:** ignored; it has no effect on the latched parameters.
- **Reset, including mid-transfer:** in the next cycle every output is 0 and the state is IDLE:
  - `cyc`, `stb`, `we`, `adr`, `sel`, `dat_o` = 0;
  - `busy_o`, `done_o`, `err_o`, `count_o` = 0;
  - the buffer and the watchdog also reset.

## Timing

Cycle numbering: `start_i` is sampled at the edge that ends cycle 0.

- **Cycle 1:** `busy_o`=1, `cyc`=`stb`=1, READ on `src`.
- **Phase hand-off:** an `ack` sampled at the end of cycle k changes the phase in cycle k+1. The master has zero idle cycles between phases.
- **With a single-cycle registered-ack slave** (`ack` visible one cycle after `stb`):
  - each word takes 4 cycles: read `stb` in cycle 4n+1, read `ack` in 4n+2, write `stb` in 4n+3, write `ack` in 4n+4;
  - after the last word's write `ack` (end of cycle 4L): `cyc`=0, `busy_o`=0 and `done_o`=1 in cycle 4L+1;
  - `done_o`=0 again from cycle 4L+2.
- **Slave compatibility:** the master does not re-count the `ack`-high cycle. A slave that guards on `~ack` sees a fresh request in the next phase.
- **`count_o`** updates in the cycle after each write `ack`.
- **`len_i`=0:** `done_o`=1 in cycle 1 only.
- **Error timing:** `err`/timeout sampled at the end of cycle k gives `cyc`=0, `err_o`=1 and `done_o`=1 in cycle k+1.

## Test plan

Use one-cycle-ack SRAM slave models unless noted.

- **Basic copy:** preload words 0x11111111..0x44444444 at 0x000; `src`=0x000, `dst`=0x100, `len`=4, start.
  - Words 0x100..0x10C match the source.
  - `done_o` is high in cycle 17 only.
  - `count_o`=4; `err_o`=0; `cyc` is high in cycles 1–16 only.
- **Zero length:** `len`=0, start.
  - `done_o` is high in cycle 1.
  - No `stb` at any time; `busy_o` never rises.
- **Bus error:** `wbm_err_i` asserted on the 3rd write phase (`len`=5).
  - The cycle after: `cyc`=0, `err_o`=1, one `done_o` pulse.
  - `count_o`=2.
  - `err_o` clears on the next accepted start.
- **Timeout:** `TIMEOUT_CYCLES`=8 and a slave that never acks.
  - `cyc` drops and `err_o`=1 in cycle 9 after the read `stb` rose.
- **Ignored start and address wrap:** `ADDR_WIDTH`=16, `src`=0xFFFC, `len`=2.
  - A second read targets 0x0000.
  - A `start_i` pulse with new parameters mid-transfer is ignored: addresses and length are unchanged.
- **Reset mid-transfer:** assert `wb_rst_i` during a WRITE phase.
  - In the next cycle all outputs are 0.
  - A new start afterwards completes normally.
